// File: rtl/vga_timer_gen.sv
// Raster timing generator. It produces sync, visible, position and line/frame strobes for any H/V timing set.
// It advances on a pixel-clock enable, and the outputs are aligned to a pixel pipeline through a tick-qualified delay line.
module vga_timer_gen #(
    parameter int H_VISIBLE   = 640,
    parameter int H_FRONT     = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BACK      = 48,
    parameter int V_VISIBLE   = 480,
    parameter int V_FRONT     = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BACK      = 33,
    parameter bit HSYNC_POL   = 1'b0,
    parameter bit VSYNC_POL   = 1'b0,
    parameter int PIPE_DEPTH  = 0,
    parameter int FRAME_CNT_W = 16,
    localparam int WHOLE_LINE  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK,
    localparam int WHOLE_FRAME = V_VISIBLE + V_FRONT + V_SYNC + V_BACK,
    localparam int XW = (H_VISIBLE > 1) ? $clog2(H_VISIBLE) : 1,
    localparam int YW = (V_VISIBLE > 1) ? $clog2(V_VISIBLE) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   pix_en_i,
    output logic                   hsync_o,
    output logic                   vsync_o,
    output logic                   visible_o,
    output logic [XW-1:0]          position_x_o,
    output logic [YW-1:0]          position_y_o,
    output logic                   line_start_o,
    output logic                   frame_start_o,
    output logic [FRAME_CNT_W-1:0] frame_count_o
);

    localparam int CXW = (WHOLE_LINE > 1) ? $clog2(WHOLE_LINE) : 1;
    localparam int CYW = (WHOLE_FRAME > 1) ? $clog2(WHOLE_FRAME) : 1;

    localparam logic [CXW-1:0] X_LAST     = CXW'(WHOLE_LINE - 1);
    localparam logic [CYW-1:0] Y_LAST     = CYW'(WHOLE_FRAME - 1);
    localparam logic [CYW-1:0] Y_VIS_LAST = CYW'(V_VISIBLE - 1);

    localparam int HS_START = H_VISIBLE + H_FRONT;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_VISIBLE + V_FRONT;
    localparam int VS_END   = VS_START + V_SYNC;

    typedef struct packed {
        logic          hsync;
        logic          vsync;
        logic          visible;
        logic [XW-1:0] position_x;
        logic [YW-1:0] position_y;
        logic          line_start;
        logic          frame_start;
    } stage_t;

    localparam stage_t IDLE = {!HSYNC_POL, !VSYNC_POL, 1'b0, {XW{1'b0}}, {YW{1'b0}}, 2'b00};

    logic [CXW-1:0] x;
    logic [CYW-1:0] y;
    logic [31:0]    x_ext;
    logic [31:0]    y_ext;
    logic           tick_q;
    stage_t         stage0;
    stage_t         out_stage;

    assign x_ext = 32'(x);
    assign y_ext = 32'(y);

    // Reset parks the counters on the last pixel so the first tick lands on (0,0).
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            x             <= X_LAST;
            y             <= Y_LAST;
            frame_count_o <= '0;
            tick_q        <= 1'b0;
        end else begin
            tick_q <= pix_en_i;
            if (pix_en_i) begin
                if (x == X_LAST) begin
                    x <= '0;
                    y <= (y == Y_LAST) ? '0 : y + 1'b1;
                    if (y == Y_VIS_LAST) begin
                        frame_count_o <= frame_count_o + 1'b1;
                    end
                end else begin
                    x <= x + 1'b1;
                end
            end
        end
    end

    always_comb begin
        logic vis;
        logic hs_act;
        logic vs_act;
        vis    = (x_ext < H_VISIBLE) && (y_ext < V_VISIBLE);
        hs_act = (x_ext >= HS_START) && (x_ext < HS_END);
        vs_act = (y_ext >= VS_START) && (y_ext < VS_END);
        stage0             = IDLE;
        stage0.visible     = vis;
        stage0.hsync       = hs_act ? HSYNC_POL : !HSYNC_POL;
        stage0.vsync       = vs_act ? VSYNC_POL : !VSYNC_POL;
        stage0.position_x  = vis ? x[XW-1:0] : '0;
        stage0.position_y  = vis ? y[YW-1:0] : '0;
        stage0.line_start  = (x == '0);
        stage0.frame_start = (x == '0) && (y == '0);
    end

    generate
        if (PIPE_DEPTH == 0) begin : g_direct
            assign out_stage = stage0;
        end else begin : g_pipe
            stage_t pipe [PIPE_DEPTH];

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    for (int i = 0; i < PIPE_DEPTH; i++) begin
                        pipe[i] <= IDLE;
                    end
                end else if (pix_en_i) begin
                    pipe[0] <= stage0;
                    for (int i = 1; i < PIPE_DEPTH; i++) begin
                        pipe[i] <= pipe[i-1];
                    end
                end
            end

            assign out_stage = pipe[PIPE_DEPTH-1];
        end
    endgenerate

    assign hsync_o      = out_stage.hsync;
    assign vsync_o      = out_stage.vsync;
    assign visible_o    = out_stage.visible;
    assign position_x_o = out_stage.position_x;
    assign position_y_o = out_stage.position_y;

    // Strobes are only shown in the cycle right after a tick, so they never stretch across stalls.
    assign line_start_o  = out_stage.line_start  & tick_q;
    assign frame_start_o = out_stage.frame_start & tick_q;

endmodule
